// File: rtl/fpu_sequencer_pkg.sv
// Shared constants for the FP sequencer: opcodes, unit indices, compare codes, FP field ranges.
// Pure definitions; no logic, no latency.
// No flow control here; consumers own their handshakes.
package fpu_sequencer_pkg;

    localparam logic [2:0] OP_FADD = 3'd0;
    localparam logic [2:0] OP_FSUB = 3'd1;
    localparam logic [2:0] OP_FMUL = 3'd2;
    localparam logic [2:0] OP_FDIV = 3'd3;
    localparam logic [2:0] OP_FCMP = 3'd4;

    localparam logic [1:0] U_ADD = 2'd0;
    localparam logic [1:0] U_MUL = 2'd1;
    localparam logic [1:0] U_DIV = 2'd2;

    localparam logic [1:0] CMP_EQ = 2'b00;
    localparam logic [1:0] CMP_LT = 2'b01;
    localparam logic [1:0] CMP_GT = 2'b10;

    // sign at the top, magnitude is exponent plus fraction
    localparam int SIGN   = 30;
    localparam int MAG_HI = 29;
    localparam int MAG_LO = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    function automatic logic [1:0] unit_of(input logic [2:0] op);
        case (op)
            OP_FMUL: return U_MUL;
            OP_FDIV: return U_DIV;
            default: return U_ADD;
        endcase
    endfunction

endpackage

// File: rtl/fpu_sequencer_if.sv
// CPU-side request/response bundle of the FP sequencer.
// Wires only; zero latency.
// No backpressure: requests are dropped unless the sequencer is idle.
interface fpu_sequencer_if #(
    parameter int W = 31
);
    logic         req;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         ovf;
    logic [1:0]   cmp;

    modport master (
        output req, op, a, b,
        input  busy, done, result, ovf, cmp
    );

    modport slave (
        input  req, op, a, b,
        output busy, done, result, ovf, cmp
    );
endinterface

// File: rtl/fpu_result_mux.sv
// Picks the finishing unit's result/overflow and decodes the FCMP outcome from the fadd difference.
// Purely combinational, zero latency.
// No flow control; caller samples it only on the target unit's completion.
module fpu_result_mux
    import fpu_sequencer_pkg::*;
#(
    parameter int W = 31
) (
    input  logic [1:0]   sel,
    input  logic         is_cmp,
    input  logic [W-1:0] a,
    input  logic [W-1:0] add_out,
    input  logic [W-1:0] mul_out,
    input  logic [W-1:0] div_out,
    input  logic [2:0]   u_ovf,
    output logic [W-1:0] res,
    output logic         ovf,
    output logic [1:0]   cmp
);

    always_comb begin
        res = add_out;
        ovf = u_ovf[U_ADD];
        cmp = CMP_EQ;
        case (sel)
            U_MUL: begin
                res = mul_out;
                ovf = u_ovf[U_MUL];
            end
            U_DIV: begin
                res = div_out;
                ovf = u_ovf[U_DIV];
            end
            default: ;
        endcase
        // FCMP runs a-b through fadd; only the sign/zero of the difference matters
        if (is_cmp) begin
            res = a;
            ovf = 1'b0;
            if (add_out[MAG_HI:MAG_LO] == '0) begin
                cmp = CMP_EQ;
            end else if (add_out[SIGN]) begin
                cmp = CMP_LT;
            end else begin
                cmp = CMP_GT;
            end
        end
    end

endmodule

// File: rtl/fpu_sequencer.sv
// Single-issue controller for fadd/fmul/fdiv; optional WAIT abort under FPU_SEQ_TIMEOUT_EN.
// Latency: done L+3 cycles after the accepting edge (L = u_start to u_done), 2 for divide-by-zero.
// No queue: req outside IDLE is ignored and must be re-issued by the CPU.
module fpu_sequencer
    import fpu_sequencer_pkg::*;
#(
    parameter int W = 31
`ifdef FPU_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 63
`endif
) (
    input  logic          clk,
    input  logic          reset,
    fpu_sequencer_if.slave cpu,
    output logic [W-1:0]  u_in1,
    output logic [W-1:0]  u_in2,
    output logic          u_sub,
    output logic [2:0]    u_start,
    input  logic [2:0]    u_done,
    input  logic [2:0]    u_ovf,
    input  logic [W-1:0]  add_out,
    input  logic [W-1:0]  mul_out,
    input  logic [W-1:0]  div_out
);

    state_e       state_q, state_d;
    logic [1:0]   unit_q;
    logic         is_cmp_q;
    logic         busy_q;
    logic         done_q;
    logic [W-1:0] result_q;
    logic         ovf_q;
    logic [1:0]   cmp_q;
    logic [W-1:0] cap_res_q;
    logic         cap_ovf_q;
    logic [1:0]   cap_cmp_q;

    logic         req_ok;
    logic         div_zero;
    logic         tgt_done;
    logic         timeout_hit;
    logic [W-1:0] mux_res;
    logic         mux_ovf;
    logic [1:0]   mux_cmp;

    assign req_ok   = cpu.req && (cpu.op <= OP_FCMP);
    assign div_zero = (cpu.op == OP_FDIV) && (cpu.b[MAG_HI:MAG_LO] == '0);
    assign tgt_done = u_done[unit_q];

`ifdef FPU_SEQ_TIMEOUT_EN
    logic [5:0] wait_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else if (state_q == S_ISSUE) begin
            wait_cnt_q <= '0;
        end else if (state_q == S_WAIT) begin
            wait_cnt_q <= wait_cnt_q + 6'd1;
        end
    end

    // fires on the last of TIMEOUT WAIT cycles
    assign timeout_hit = (state_q == S_WAIT) && (wait_cnt_q == 6'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    fpu_result_mux #(.W(W)) u_mux (
        .sel     (unit_q),
        .is_cmp  (is_cmp_q),
        .a       (u_in1),
        .add_out (add_out),
        .mul_out (mul_out),
        .div_out (div_out),
        .u_ovf   (u_ovf),
        .res     (mux_res),
        .ovf     (mux_ovf),
        .cmp     (mux_cmp)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        u_start = '0;
        case (state_q)
            S_IDLE: begin
                if (req_ok) begin
                    state_d = div_zero ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                u_start[unit_q] = 1'b1;
                state_d         = S_WAIT;
            end
            S_WAIT: begin
                if (tgt_done || timeout_hit) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            unit_q    <= U_ADD;
            is_cmp_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
            cmp_q     <= CMP_EQ;
            cap_res_q <= '0;
            cap_ovf_q <= 1'b0;
            cap_cmp_q <= CMP_EQ;
            u_in1     <= '0;
            u_in2     <= '0;
            u_sub     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_ok) begin
                        u_in1    <= cpu.a;
                        u_in2    <= cpu.b;
                        u_sub    <= (cpu.op == OP_FSUB) || (cpu.op == OP_FCMP);
                        unit_q   <= unit_of(cpu.op);
                        is_cmp_q <= (cpu.op == OP_FCMP);
                        busy_q   <= 1'b1;
                        if (div_zero) begin
                            cap_res_q <= cpu.a;
                            cap_ovf_q <= 1'b1;
                            cap_cmp_q <= CMP_EQ;
                        end
                    end
                end
                S_WAIT: begin
                    if (tgt_done) begin
                        cap_res_q <= mux_res;
                        cap_ovf_q <= mux_ovf;
                        cap_cmp_q <= mux_cmp;
                    end else if (timeout_hit) begin
                        cap_res_q <= u_in1;
                        cap_ovf_q <= 1'b1;
                        cap_cmp_q <= CMP_EQ;
                    end
                end
                S_DONE: begin
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    result_q <= cap_res_q;
                    ovf_q    <= cap_ovf_q;
                    cmp_q    <= cap_cmp_q;
                end
                default: ;
            endcase
        end
    end

    assign cpu.busy   = busy_q;
    assign cpu.done   = done_q;
    assign cpu.result = result_q;
    assign cpu.ovf    = ovf_q;
    assign cpu.cmp    = cmp_q;

endmodule
